// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bit indices, MEM-stage FSM encoding and the WB bubble value.
`timescale 1ns/1ps
package pipe_pkg;
   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;
   localparam int M_MEMREAD   = 1;
   localparam int M_MEMWRITE  = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } mem_state_e;

   localparam logic [1:0] BUBBLE_WB = 2'b00;
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. load_i captures all fields; bubble_i forces WB control to the
// bubble value, and on its own (without load_i) leaves the data fields untouched.
`timescale 1ns/1ps
module mem_wb_reg
   import pipe_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        bubble_i,
   input  logic [1:0]  wb_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] alu_i,
   input  logic [4:0]  reg_i,
   output logic [1:0]  wb_o,
   output logic [31:0] rdata_o,
   output logic [31:0] alu_o,
   output logic [4:0]  reg_o
);
   logic [1:0]  wb_q, wb_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] alu_q, alu_d;
   logic [4:0]  reg_q, reg_d;

   always_comb begin
      wb_d    = wb_q;
      rdata_d = rdata_q;
      alu_d   = alu_q;
      reg_d   = reg_q;
      if (load_i) begin
         wb_d    = wb_i;
         rdata_d = rdata_i;
         alu_d   = alu_i;
         reg_d   = reg_i;
      end
      if (bubble_i) wb_d = BUBBLE_WB;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_q    <= '0;
         rdata_q <= '0;
         alu_q   <= '0;
         reg_q   <= '0;
      end else begin
         wb_q    <= wb_d;
         rdata_q <= rdata_d;
         alu_q   <= alu_d;
         reg_q   <= reg_d;
      end
   end

   assign wb_o    = wb_q;
   assign rdata_o = rdata_q;
   assign alu_o   = alu_q;
   assign reg_o   = reg_q;
endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: req/ack data-memory FSM with timeout, error detection,
// upstream stall generation, and the MEM/WB register feeding write-back.
`timescale 1ns/1ps
module mem_stage
   import pipe_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int AW      = 32
)(
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    MEM_WB,
   input  logic [1:0]    MEM_M,
   input  logic [31:0]   MEM_ALU_out,
   input  logic [31:0]   DM_Wdata,
   input  logic [4:0]    MEM_writeReg,
   output logic          stall,
   output logic          DM_req,
   output logic          DM_we,
   output logic [AW-1:0] DM_addr,
   output logic [31:0]   DM_wdata,
   input  logic [31:0]   DM_rdata,
   input  logic          DM_ack,
   output logic [1:0]    WB_WB,
   output logic [31:0]   WB_ReadData,
   output logic [31:0]   WB_ALU_out,
   output logic [4:0]    WB_writeReg,
   output logic          mem_err,
   output logic [1:0]    dbg_state_o
);
   // Abort fires on the WAIT edge where the incremented count would hit TIMEOUT-1,
   // giving TIMEOUT request cycles in total (one REQ plus TIMEOUT-1 WAIT).
   localparam logic [7:0] CNT_ABORT = 8'(TIMEOUT - 2);

   mem_state_e state_q;
   logic [7:0] cnt_q;
   logic       err_q;

   logic mem_op, bad_op, valid_op, busy, ack_hit, abort;
   logic wb_load, wb_bubble;
   logic [31:0] rdata_in;

   assign mem_op   = MEM_M[M_MEMREAD] | MEM_M[M_MEMWRITE];
   assign bad_op   = (MEM_M[M_MEMREAD] & MEM_M[M_MEMWRITE]) | (mem_op & (MEM_ALU_out[1:0] != 2'b00));
   assign valid_op = mem_op & ~bad_op;
   assign busy     = (state_q == REQ) || (state_q == WAIT);
   assign ack_hit  = busy & DM_ack;
   assign abort    = (state_q == WAIT) & ~DM_ack & (cnt_q == CNT_ABORT);

   assign stall = ~rst & (((state_q == IDLE) & valid_op) | (busy & ~DM_ack & ~abort));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bad_op)        err_q   <= 1'b1;
               else if (valid_op) state_q <= REQ;
            end
            REQ: begin
               if (DM_ack) state_q <= IDLE;
               else begin
                  state_q <= WAIT;
                  cnt_q   <= '0;
               end
            end
            WAIT: begin
               if (DM_ack) state_q <= IDLE;
               else if (abort) begin
                  state_q <= IDLE;
                  err_q   <= 1'b1;
               end else cnt_q <= cnt_q + 8'd1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign DM_req      = busy;
   assign DM_we       = busy & MEM_M[M_MEMWRITE];
   assign DM_addr     = MEM_ALU_out[AW-1:0];
   assign DM_wdata    = DM_Wdata;
   assign mem_err     = err_q;
   assign dbg_state_o = state_q;

   // Non-memory ops, rejected ops, completions and aborts all advance the register;
   // a stalled cycle only injects a bubble.
   assign wb_load   = ((state_q == IDLE) & ~valid_op) | ack_hit | abort;
   assign wb_bubble = ((state_q == IDLE) & bad_op) | abort | stall;
   assign rdata_in  = (ack_hit & MEM_M[M_MEMREAD]) ? DM_rdata : 32'd0;

   mem_wb_reg u_mem_wb_reg (
      .clk      (clk),
      .rst      (rst),
      .load_i   (wb_load),
      .bubble_i (wb_bubble),
      .wb_i     (MEM_WB),
      .rdata_i  (rdata_in),
      .alu_i    (MEM_ALU_out),
      .reg_i    (MEM_writeReg),
      .wb_o     (WB_WB),
      .rdata_o  (WB_ReadData),
      .alu_o    (WB_ALU_out),
      .reg_o    (WB_writeReg)
   );
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load with waits, zero-wait store,
// rejected ops, timeout abort and asynchronous reset mid-access.
`timescale 1ns/1ps
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  MEM_WB, MEM_M;
  logic [31:0] MEM_ALU_out, DM_Wdata, DM_rdata;
  logic [4:0]  MEM_writeReg;
  logic        DM_ack;
  logic        stall, DM_req, DM_we, mem_err;
  logic [31:0] DM_addr, DM_wdata, WB_ReadData, WB_ALU_out;
  logic [1:0]  WB_WB, dbg_state;
  logic [4:0]  WB_writeReg;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(4), .AW(32)) dut (
    .clk(clk), .rst(rst), .MEM_WB(MEM_WB), .MEM_M(MEM_M), .MEM_ALU_out(MEM_ALU_out),
    .DM_Wdata(DM_Wdata), .MEM_writeReg(MEM_writeReg), .stall(stall), .DM_req(DM_req),
    .DM_we(DM_we), .DM_addr(DM_addr), .DM_wdata(DM_wdata), .DM_rdata(DM_rdata),
    .DM_ack(DM_ack), .WB_WB(WB_WB), .WB_ReadData(WB_ReadData), .WB_ALU_out(WB_ALU_out),
    .WB_writeReg(WB_writeReg), .mem_err(mem_err), .dbg_state_o(dbg_state)
  );

  // Inputs are driven and outputs sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] m, input logic [1:0] wb, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [4:0] rd);
    MEM_M = m; MEM_WB = wb; MEM_ALU_out = alu; DM_Wdata = wd; MEM_writeReg = rd;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; DM_ack = 1'b0; DM_rdata = 32'h0;
    set_in(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    tick(); tick();
    n_vec++;
    if ({stall, DM_req, mem_err, WB_WB, WB_ReadData, WB_ALU_out, WB_writeReg} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: stall=%b req=%b err=%b wb=%b rd=%h alu=%h reg=%0d, required all 0",
               stall, DM_req, mem_err, WB_WB, WB_ReadData, WB_ALU_out, WB_writeReg);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    set_in(2'b00, 2'b10, 32'h1234, 32'h0, 5'd5);
    n_vec++;
    if (stall !== 1'b0 || DM_req !== 1'b0) begin
      n_err++; $display("FAIL alu_no_stall: stall=%b req=%b, required 0 0", stall, DM_req);
    end
    tick();
    n_vec++;
    if (WB_WB !== 2'b10 || WB_ALU_out !== 32'h1234 || WB_writeReg !== 5'd5 || WB_ReadData !== 32'h0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL alu_result: wb=%b alu=%h reg=%0d rd=%h stall=%b, required 10 1234 5 0 0",
               WB_WB, WB_ALU_out, WB_writeReg, WB_ReadData, stall);
    end
  endtask

  task automatic test_load_wait();
    int stall_cycles = 0;
    set_in(2'b10, 2'b11, 32'h40, 32'h0, 5'd7);
    n_vec++;
    if (stall !== 1'b1 || DM_req !== 1'b0) begin
      n_err++; $display("FAIL load_idle: stall=%b req=%b, required 1 0", stall, DM_req);
    end
    if (stall) stall_cycles++;
    tick();
    n_vec++;
    if (DM_req !== 1'b1 || DM_we !== 1'b0 || DM_addr !== 32'h40 || WB_WB !== 2'b00) begin
      n_err++;
      $display("FAIL load_req: req=%b we=%b addr=%h wb=%b, required 1 0 40 00", DM_req, DM_we, DM_addr, WB_WB);
    end
    if (stall) stall_cycles++;
    tick();
    n_vec++;
    if (DM_req !== 1'b1 || WB_WB !== 2'b00) begin
      n_err++; $display("FAIL load_wait: req=%b wb=%b, required 1 00", DM_req, WB_WB);
    end
    if (stall) stall_cycles++;
    tick();
    DM_ack = 1'b1; DM_rdata = 32'hDEADBEEF;
    #1;
    if (stall) stall_cycles++;
    n_vec++;
    if (stall_cycles != 3 || DM_req !== 1'b1) begin
      n_err++; $display("FAIL load_stall_len: stall cycles=%0d req=%b, required 3 1", stall_cycles, DM_req);
    end
    tick();
    DM_ack = 1'b0; DM_rdata = 32'h0;
    n_vec++;
    if (WB_WB !== 2'b11 || WB_ReadData !== 32'hDEADBEEF || WB_ALU_out !== 32'h40 || WB_writeReg !== 5'd7 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL load_result: wb=%b rd=%h alu=%h reg=%0d st=%0d, required 11 deadbeef 40 7 0",
               WB_WB, WB_ReadData, WB_ALU_out, WB_writeReg, dbg_state);
    end
  endtask

  task automatic test_store_zero_wait();
    set_in(2'b01, 2'b01, 32'h80, 32'hA5A5A5A5, 5'd0);
    tick();
    DM_ack = 1'b1; DM_rdata = 32'h11111111;
    #1;
    n_vec++;
    if (DM_req !== 1'b1 || DM_we !== 1'b1 || DM_addr !== 32'h80 || DM_wdata !== 32'hA5A5A5A5 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL store_req: req=%b we=%b addr=%h wdata=%h stall=%b, required 1 1 80 a5a5a5a5 0",
               DM_req, DM_we, DM_addr, DM_wdata, stall);
    end
    tick();
    DM_ack = 1'b0; DM_rdata = 32'h0;
    set_in(2'b00, 2'b10, 32'h0, 32'h0, 5'd1);
    n_vec++;
    if (WB_WB !== 2'b01 || WB_ReadData !== 32'h0 || WB_ALU_out !== 32'h80 || DM_req !== 1'b0) begin
      n_err++;
      $display("FAIL store_result: wb=%b rd=%h alu=%h req=%b, required 01 0 80 0", WB_WB, WB_ReadData, WB_ALU_out, DM_req);
    end
    tick();
  endtask

  task automatic test_rejected(input logic [1:0] m, input logic [31:0] addr, input logic [4:0] rd);
    set_in(m, 2'b11, addr, 32'h0, rd);
    n_vec++;
    if (stall !== 1'b0 || DM_req !== 1'b0) begin
      n_err++; $display("FAIL reject_no_req m=%b: stall=%b req=%b, required 0 0", m, stall, DM_req);
    end
    tick();
    n_vec++;
    if (WB_WB !== 2'b00 || mem_err !== 1'b1 || WB_ALU_out !== addr || WB_writeReg !== rd || DM_req !== 1'b0) begin
      n_err++;
      $display("FAIL reject_bubble m=%b: wb=%b err=%b alu=%h reg=%0d req=%b, required 00 1 %h %0d 0",
               m, WB_WB, mem_err, WB_ALU_out, WB_writeReg, DM_req, addr, rd);
    end
    set_in(2'b00, 2'b10, 32'h0, 32'h0, 5'd0);
    tick();
    n_vec++;
    if (mem_err !== 1'b0 || WB_WB !== 2'b10) begin
      n_err++; $display("FAIL reject_pulse m=%b: err=%b wb=%b, required 0 10", m, mem_err, WB_WB);
    end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    set_in(2'b10, 2'b11, 32'h200, 32'h0, 5'd9);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (DM_req) begin
        req_cycles++;
        if (mem_err !== 1'b0) begin
          n_err++; $display("FAIL timeout_early_err: err=1 at req cycle %0d, required 0", req_cycles);
        end
      end else break;
    end
    n_vec++;
    if (req_cycles != 4 || mem_err !== 1'b1 || WB_WB !== 2'b00 || dbg_state !== 2'd0 || WB_ReadData !== 32'h0) begin
      n_err++;
      $display("FAIL timeout_abort: req cycles=%0d err=%b wb=%b st=%0d rd=%h, required 4 1 00 0 0",
               req_cycles, mem_err, WB_WB, dbg_state, WB_ReadData);
    end
    set_in(2'b00, 2'b10, 32'h55, 32'h0, 5'd2);
    tick();
    n_vec++;
    if (WB_WB !== 2'b10 || WB_ALU_out !== 32'h55 || WB_writeReg !== 5'd2 || mem_err !== 1'b0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_recover: wb=%b alu=%h reg=%0d err=%b stall=%b, required 10 55 2 0 0",
               WB_WB, WB_ALU_out, WB_writeReg, mem_err, stall);
    end
  endtask

  task automatic test_reset_mid();
    set_in(2'b10, 2'b11, 32'h300, 32'h0, 5'd4);
    tick(); tick();
    n_vec++;
    if (dbg_state !== 2'd2 || DM_req !== 1'b1) begin
      n_err++; $display("FAIL rstmid_in_wait: st=%0d req=%b, required 2 1", dbg_state, DM_req);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({stall, DM_req, mem_err, WB_WB, WB_ReadData, WB_ALU_out, WB_writeReg, dbg_state} !== '0) begin
      n_err++;
      $display("FAIL rstmid_clear: stall=%b req=%b err=%b wb=%b rd=%h alu=%h reg=%0d st=%0d, required all 0",
               stall, DM_req, mem_err, WB_WB, WB_ReadData, WB_ALU_out, WB_writeReg, dbg_state);
    end
    tick();
    rst = 1'b0;
    set_in(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    DM_ack = 1'b1; DM_rdata = 32'hDEADBEEF;
    tick();
    DM_ack = 1'b0;
    n_vec++;
    if (DM_req !== 1'b0 || WB_ReadData !== 32'h0 || dbg_state !== 2'd0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_late_ack: req=%b rd=%h st=%0d stall=%b, required 0 0 0 0", DM_req, WB_ReadData, dbg_state, stall);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store_zero_wait();
    test_rejected(2'b10, 32'h42, 5'd3);
    test_rejected(2'b11, 32'h100, 5'd6);
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
